// File: rtl/aibcr3aux_por_seq.sv
// AIB aux-channel power-on / link-up sequencer: synchronises dn_por and crdet, then
// releases IO enable and adapter reset in order. Optional WAIT_REM timeout: AIBCR3AUX_POR_TIMEOUT_EN.
module aibcr3aux_por_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int DBNC_CYC    = 16,
  parameter int REL_DLY     = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       dn_por_async_i,
  input  logic       crdet_async_i,
  input  logic       local_por_done_i,
  input  logic       cfg_done_i,
  output logic       io_en_o,
  output logic       adapter_rst_o,
  output logic       por_ready_o,
  output logic [2:0] seq_state_o
`ifdef AIBCR3AUX_POR_TIMEOUT_EN
  ,
  output logic       por_timeout_o
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DETECT    = 3'd1,
    ST_DEBOUNCE  = 3'd2,
    ST_WAIT_REM  = 3'd3,
    ST_IO_EN     = 3'd4,
    ST_ADAPT_REL = 3'd5,
    ST_ACTIVE    = 3'd6,
    ST_FAULT     = 3'd7
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] DBNC_LAST = CNT_W'(DBNC_CYC - 1);
  localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(REL_DLY - 1);

  logic [SYNC_STAGES-1:0] dn_sync_q;
  logic [SYNC_STAGES-1:0] cr_sync_q;
  logic                   dn_por_s;
  logic                   crdet_s;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   cnt_inc_s;
  logic                   abort_s;
  logic                   in_link_s;
  logic                   in_up_s;
  logic                   io_en_q, adapter_rst_q, por_ready_q;

  // Pad synchronisers; reset to "remote in reset, no partner"
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dn_sync_q <= {SYNC_STAGES{1'b1}};
      cr_sync_q <= {SYNC_STAGES{1'b0}};
    end else begin
      dn_sync_q <= {dn_sync_q[SYNC_STAGES-2:0], dn_por_async_i};
      cr_sync_q <= {cr_sync_q[SYNC_STAGES-2:0], crdet_async_i};
    end
  end

  assign dn_por_s  = dn_sync_q[SYNC_STAGES-1];
  assign crdet_s   = cr_sync_q[SYNC_STAGES-1];
  assign in_link_s = (state_q inside {ST_WAIT_REM, ST_IO_EN, ST_ADAPT_REL, ST_ACTIVE});
  assign in_up_s   = (state_q inside {ST_IO_EN, ST_ADAPT_REL, ST_ACTIVE});
  assign abort_s   = (state_q != ST_IDLE) && (state_q != ST_FAULT) &&
                     (!local_por_done_i || (in_link_s && !crdet_s) || (in_up_s && dn_por_s));

`ifdef AIBCR3AUX_POR_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0] tmo_q, tmo_d;
  logic        por_timeout_q;
`endif

  // Next-state, delay counter and timeout counter
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cnt_inc_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (local_por_done_i && cfg_done_i) state_d = ST_DETECT;
        else                                state_d = ST_IDLE;
      end
      ST_DETECT: begin
        if (crdet_s) state_d = ST_DEBOUNCE;
        else         state_d = ST_DETECT;
      end
      ST_DEBOUNCE: begin
        if (!crdet_s)                 state_d = ST_DETECT;
        else if (cnt_q == DBNC_LAST)  state_d = ST_WAIT_REM;
        else                          cnt_inc_s = 1'b1;
      end
      ST_WAIT_REM: begin
        if (!dn_por_s)               state_d = ST_IO_EN;
`ifdef AIBCR3AUX_POR_TIMEOUT_EN
        else if (tmo_q == TMO_LAST)  state_d = ST_FAULT;
`endif
        else                         state_d = ST_WAIT_REM;
      end
      ST_IO_EN: begin
        if (cnt_q == REL_LAST) state_d = ST_ADAPT_REL;
        else                   cnt_inc_s = 1'b1;
      end
      ST_ADAPT_REL: state_d = ST_ACTIVE;
      ST_ACTIVE:    state_d = ST_ACTIVE;
      ST_FAULT:     state_d = ST_FAULT;
      default:      state_d = ST_IDLE;
    endcase

    // Aborts outrank every normal advance taken above
    if (abort_s) state_d = ST_IDLE;
    else         state_d = state_d;

    if (state_d != state_q)                   cnt_d = {CNT_W{1'b0}};
    else if (cnt_inc_s && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
    else                                      cnt_d = cnt_q;

`ifdef AIBCR3AUX_POR_TIMEOUT_EN
    if ((state_q == ST_WAIT_REM) && (state_d == ST_WAIT_REM)) tmo_d = tmo_q + 16'd1;
    else                                                      tmo_d = 16'd0;
`endif
  end

  // State, counters and outputs; outputs decode next_state so they move with seq_state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      cnt_q         <= {CNT_W{1'b0}};
      io_en_q       <= 1'b0;
      adapter_rst_q <= 1'b1;
      por_ready_q   <= 1'b0;
`ifdef AIBCR3AUX_POR_TIMEOUT_EN
      tmo_q         <= 16'd0;
      por_timeout_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      io_en_q       <= (state_d inside {ST_IO_EN, ST_ADAPT_REL, ST_ACTIVE});
      adapter_rst_q <= !(state_d inside {ST_ADAPT_REL, ST_ACTIVE});
      por_ready_q   <= (state_d == ST_ACTIVE);
`ifdef AIBCR3AUX_POR_TIMEOUT_EN
      tmo_q         <= tmo_d;
      por_timeout_q <= por_timeout_q | (state_d == ST_FAULT);
`endif
    end
  end

  assign io_en_o       = io_en_q;
  assign adapter_rst_o = adapter_rst_q;
  assign por_ready_o   = por_ready_q;
  assign seq_state_o   = state_q;
`ifdef AIBCR3AUX_POR_TIMEOUT_EN
  assign por_timeout_o = por_timeout_q;
`endif

endmodule
